// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants, ID/EX bundle type and small decode helpers
// for the 5-stage MIPS pipeline.
package cpu_pkg;

  localparam int NREG = 32;
  localparam int XLEN = 32;
  localparam int AW   = $clog2(NREG);

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] rega;
    logic [XLEN-1:0] regb;
    logic [AW-1:0]   dest;
    logic            is_load;
    logic            valid;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '{
    instr:   NOP_INSTR,
    rega:    '0,
    regb:    '0,
    dest:    '0,
    is_load: 1'b0,
    valid:   1'b0
  };

  function automatic logic [AW-1:0] dest_of(
    input logic [5:0]    op,
    input logic [AW-1:0] rt,
    input logic [AW-1:0] rd
  );
    logic [AW-1:0] d;
    d = '0;
    unique case (op)
      OP_RTYPE: d = rd;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
      OP_XORI, OP_SLTI, OP_SLTIU, OP_LW:
        d = rt;
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic uses_rt(
    input logic [5:0] op
  );
    return (op == OP_RTYPE) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // EX/MEM forward beats same-cycle writeback; $0 never matches.
  function automatic logic [XLEN-1:0] resolve(
    input logic [AW-1:0]   addr,
    input logic            fwd_en,
    input logic [AW-1:0]   fwd_addr,
    input logic [XLEN-1:0] fwd_data,
    input logic            wb_en,
    input logic [AW-1:0]   wb_addr,
    input logic [XLEN-1:0] wb_data,
    input logic [XLEN-1:0] rf_data
  );
    logic [XLEN-1:0] r;
    r = rf_data;
    if (addr != '0) begin
      if (fwd_en && fwd_addr == addr)
        r = fwd_data;
      else if (wb_en && wb_addr == addr)
        r = wb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-stage bus: IF/ID input, WB and EX/MEM bypass inputs,
// stall output and the registered ID/EX bundle.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] if_instr;
  logic            if_valid;
  logic            id_ready;
  logic            flush;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            mem_fwd_en;
  logic [AW-1:0]   mem_fwd_addr;
  logic [XLEN-1:0] mem_fwd_data;
  logic [XLEN-1:0] ex_instruction;
  logic [XLEN-1:0] ex_regA;
  logic [XLEN-1:0] ex_regB;
  logic [AW-1:0]   ex_dest;
  logic            ex_is_load;
  logic            ex_valid;

  modport master (
    output if_instr, if_valid, flush,
    output wb_en, wb_addr, wb_data,
    output mem_fwd_en, mem_fwd_addr, mem_fwd_data,
    input  id_ready,
    input  ex_instruction, ex_regA, ex_regB,
    input  ex_dest, ex_is_load, ex_valid
  );

  modport slave (
    input  if_instr, if_valid, flush,
    input  wb_en, wb_addr, wb_data,
    input  mem_fwd_en, mem_fwd_addr, mem_fwd_data,
    output id_ready,
    output ex_instruction, ex_regA, ex_regB,
    output ex_dest, ex_is_load, ex_valid
  );

endinterface

// File: rtl/id_ex_stage_reg_file.sv
// 32x32 GPR file: two async read ports, one sync write port,
// async clear, $0 hardwired to zero.
module reg_file
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/id_ex_stage.sv
// Decode / operand fetch: GPR read with bypass, load-use stall,
// and the ID/EX pipeline register feeding the ALU.
module id_ex_stage
  import cpu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  id_ex_stage_if.slave  bus
);

  logic [5:0]      opcode;
  logic [AW-1:0]   rs;
  logic [AW-1:0]   rt;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            hazard;
  id_ex_t          ex_q;
  id_ex_t          ex_d;

  assign opcode = bus.if_instr[OP_HI:OP_LO];
  assign rs     = bus.if_instr[RS_HI:RS_LO];
  assign rt     = bus.if_instr[RT_HI:RT_LO];
  assign rd     = bus.if_instr[RD_HI:RD_LO];

  reg_file u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.wb_en),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  assign op_a = resolve(rs,
    bus.mem_fwd_en, bus.mem_fwd_addr, bus.mem_fwd_data,
    bus.wb_en, bus.wb_addr, bus.wb_data, rf_a);

  assign op_b = resolve(rt,
    bus.mem_fwd_en, bus.mem_fwd_addr, bus.mem_fwd_data,
    bus.wb_en, bus.wb_addr, bus.wb_data, rf_b);

  // A lw in EX cannot forward yet; hold decode one cycle.
  assign hazard = bus.if_valid && ex_q.valid &&
                  ex_q.is_load && ex_q.dest != '0 &&
                  (ex_q.dest == rs ||
                   (uses_rt(opcode) && ex_q.dest == rt));

  assign bus.id_ready = ~hazard | bus.flush;

  always_comb begin
    ex_d = BUBBLE;
    if (!bus.flush && !hazard && bus.if_valid) begin
      ex_d.instr   = bus.if_instr;
      ex_d.rega    = op_a;
      ex_d.regb    = op_b;
      ex_d.dest    = dest_of(opcode, rt, rd);
      ex_d.is_load = (opcode == OP_LW);
      ex_d.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ex_q <= BUBBLE;
    else
      ex_q <= ex_d;
  end

  assign bus.ex_instruction = ex_q.instr;
  assign bus.ex_regA        = ex_q.rega;
  assign bus.ex_regB        = ex_q.regb;
  assign bus.ex_dest        = ex_q.dest;
  assign bus.ex_is_load     = ex_q.is_load;
  assign bus.ex_valid       = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random stimulus for id_ex_stage against a
// cycle-level behavioural model of the decode stage.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] gpr [32];
  logic [31:0] m_instr;
  logic [31:0] m_a;
  logic [31:0] m_b;
  int          m_dest;
  logic        m_load;
  logic        m_valid;
  logic        last_stall;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) gpr[i] = 0;
    m_instr = 0; m_a = 0; m_b = 0;
    m_dest = 0; m_load = 0; m_valid = 0;
    last_stall = 0;
  endtask

  function automatic logic [31:0] read_op(input int a);
    if (a == 0) return 0;
    if (bus.mem_fwd_en && int'(bus.mem_fwd_addr) == a)
      return bus.mem_fwd_data;
    if (bus.wb_en && int'(bus.wb_addr) == a)
      return bus.wb_data;
    return gpr[a];
  endfunction

  function automatic int dest_for(input logic [31:0] ins);
    int op, rt, rd;
    op = int'(ins / 32'h0400_0000);
    rt = int'((ins / 32'h1_0000) % 32);
    rd = int'((ins / 32'h800) % 32);
    if (op == 0) return rd;
    if (op inside {8, 9, 10, 11, 12, 13, 14, 35}) return rt;
    return 0;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] ins,
                        input logic fl,
                        input logic we, input int wa,
                        input logic [31:0] wd,
                        input logic fe, input int fa,
                        input logic [31:0] fd);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.flush = fl;
    bus.wb_en = we;
    bus.wb_addr = 5'(wa);
    bus.wb_data = wd;
    bus.mem_fwd_en = fe;
    bus.mem_fwd_addr = 5'(fa);
    bus.mem_fwd_data = fd;
  endtask

  task automatic cycle();
    logic [31:0] ins;
    int op, rs, rt;
    logic haz, urt;
    logic [31:0] n_instr, n_a, n_b;
    int n_dest;
    logic n_load, n_valid;
    @(negedge clk);
    ins = bus.if_instr;
    op = int'(ins / 32'h0400_0000);
    rs = int'((ins / 32'h20_0000) % 32);
    rt = int'((ins / 32'h1_0000) % 32);
    urt = op inside {0, 43, 4, 5};
    haz = bus.if_valid && m_valid && m_load && m_dest != 0 &&
          (m_dest == rs || (urt && m_dest == rt));
    chk("id_ready", 32'(bus.id_ready), 32'(!haz || bus.flush));
    if (bus.flush || haz || !bus.if_valid) begin
      n_instr = 0; n_a = 0; n_b = 0;
      n_dest = 0; n_load = 0; n_valid = 0;
    end else begin
      n_instr = ins;
      n_a = read_op(rs);
      n_b = read_op(rt);
      n_dest = dest_for(ins);
      n_load = (op == 35);
      n_valid = 1;
    end
    if (bus.wb_en && bus.wb_addr != 0)
      gpr[bus.wb_addr] = bus.wb_data;
    last_stall = haz && !bus.flush;
    @(posedge clk);
    #1;
    m_instr = n_instr; m_a = n_a; m_b = n_b;
    m_dest = n_dest; m_load = n_load; m_valid = n_valid;
    chk("ex_instruction", bus.ex_instruction, m_instr);
    chk("ex_regA", bus.ex_regA, m_a);
    chk("ex_regB", bus.ex_regB, m_b);
    chk("ex_dest", 32'(bus.ex_dest), 32'(m_dest));
    chk("ex_is_load", 32'(bus.ex_is_load), 32'(m_load));
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_instr"}, bus.ex_instruction, 32'h0);
    chk({tag, "_regA"}, bus.ex_regA, 32'h0);
    chk({tag, "_regB"}, bus.ex_regB, 32'h0);
    chk({tag, "_dest"}, 32'(bus.ex_dest), 32'h0);
    chk({tag, "_load"}, 32'(bus.ex_is_load), 32'h0);
    chk({tag, "_valid"}, 32'(bus.ex_valid), 32'h0);
  endtask

  logic [31:0] rins;
  logic [5:0]  ops [10];

  initial begin
    checks = 0;
    errors = 0;
    ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C,
            6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
    model_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_cleared("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // write-through of GPR1
    set_in(1, 32'h00200020, 0, 1, 1, 32'h7FFFFFFF, 0, 0, 0);
    cycle();
    chk("wt_regA", bus.ex_regA, 32'h7FFFFFFF);
    chk("wt_valid", 32'(bus.ex_valid), 32'h1);

    // $0 protection
    set_in(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hDEAD);
    cycle();
    set_in(1, 32'h00000020, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("r0_regA", bus.ex_regA, 32'h0);

    // forward beats writeback
    set_in(1, 32'h00400020, 0, 1, 2, 9, 1, 2, 5);
    cycle();
    chk("prio_regA", bus.ex_regA, 32'h5);
    set_in(1, 32'h00400020, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("rf_regA", bus.ex_regA, 32'h9);

    // load-use stall, then WB forwarding of the load data
    set_in(1, 32'h8C01700F, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("lw_load", 32'(bus.ex_is_load), 32'h1);
    set_in(1, 32'h00200020, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("stall_valid", 32'(bus.ex_valid), 32'h0);
    set_in(1, 32'h00200020, 0, 1, 1, 32'h1234, 0, 0, 0);
    cycle();
    chk("after_stall_regA", bus.ex_regA, 32'h1234);

    // rt filter: addi ignores rt, beq uses it
    set_in(1, 32'h8C01700F, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    set_in(1, 32'h20010001, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("addi_valid", 32'(bus.ex_valid), 32'h1);
    set_in(1, 32'h8C01700F, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    set_in(1, 32'h10010001, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("beq_stall", 32'(bus.ex_valid), 32'h0);
    cycle();
    chk("beq_issue", bus.ex_instruction, 32'h10010001);

    // flush overrides stall
    set_in(1, 32'h8C01700F, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    set_in(1, 32'h00200020, 1, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("flush_valid", 32'(bus.ex_valid), 32'h0);
    set_in(1, 32'h00221820, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("post_flush_valid", 32'(bus.ex_valid), 32'h1);

    // reset mid-run
    set_in(0, 0, 0, 1, 1, 5, 0, 0, 0);
    cycle();
    set_in(1, 32'h00200020, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("pre_rst_regA", bus.ex_regA, 32'h5);
    set_in(1, 32'h00200020, 0, 1, 1, 32'h77, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_cleared("midrst");
    model_reset();
    rst = 1'b0;
    bus.wb_en = 1'b0;
    cycle();
    chk("post_rst_regA", bus.ex_regA, 32'h0);
    chk("post_rst_valid", 32'(bus.ex_valid), 32'h1);

    // random traffic on a few registers to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        rins = {ops[$urandom_range(0, 9)],
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                11'($urandom)};
        bus.if_instr = rins;
        bus.if_valid = ($urandom_range(0, 7) != 0);
      end
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.wb_en = $urandom_range(0, 1) == 1;
      bus.wb_addr = 5'($urandom_range(0, 3));
      bus.wb_data = $urandom;
      bus.mem_fwd_en = $urandom_range(0, 2) == 0;
      bus.mem_fwd_addr = 5'($urandom_range(0, 3));
      bus.mem_fwd_data = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the ALU.
- Receives the IF/ID instruction and reads the 32x32 register file, applying MEM-stage forwarding and WB write-through.
- Drives the registered ID/EX pipeline outputs (instruction, regA, regB) that feed the ALU.
- Detects load-use hazards: it stalls the front end and inserts a bubble.

Parameters:
- NREG, 32, number of architectural registers (address width 5).
- XLEN, 32, data width.
- NOP_INSTR, 32'h00000000, bubble instruction (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- if_instr  in  32  instruction from IF/ID register
- if_valid  in  1  if_instr is a real instruction
- id_ready  out  1  combinational; 0 = stall, IF/ID must hold
- flush  in  1  branch taken/redirect; kill instruction in decode
- wb_en  in  1  writeback write enable
- wb_addr  in  5  writeback register
- wb_data  in  32  writeback data
- mem_fwd_en  in  1  EX/MEM result is valid for forwarding (non-load)
- mem_fwd_addr  in  5  EX/MEM destination register
- mem_fwd_data  in  32  EX/MEM ALU result
- ex_instruction  out  32  to ALU instruction input
- ex_regA  out  32  GPR[rs], to ALU regA
- ex_regB  out  32  GPR[rt], to ALU regB
- ex_dest  out  5  destination register (0 = none)
- ex_is_load  out  1  instruction in EX is lw
- ex_valid  out  1  ID/EX holds a real instruction

Behaviour:
- Reset (async, immediate):
  - ex_instruction=NOP_INSTR; ex_regA, ex_regB, ex_dest, ex_is_load, ex_valid all 0.
  - All register-file entries cleared to 0.
- Field decode: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
- Destination:
  - opcode 0 (R-type) -> rd.
  - addi/addiu/andi/ori/xori/slti/sltiu/lw -> rt.
  - sw/beq/bne/other -> 0.
- uses_rt: R-type, sw, beq, bne. All other formats ignore rt for hazards.
- Register $0 is hardwired to 0:
  - writes to address 0 are discarded;
  - forward and write-through matches on address 0 are ignored;
  - reading $0 always returns 0.
- Operand read priority, per operand:
  1. mem_fwd_data (mem_fwd_en and addr match);
  2. wb_data (wb_en and addr match; same-cycle write-through);
  3. register array.
- Load-use stall:
  - hazard = if_valid & ex_valid & ex_is_load & ex_dest!=0 & (ex_dest==rs | (uses_rt & ex_dest==rt)).
  - id_ready = ~hazard | flush.
- Each rising edge, ID/EX loads:
  - flush=1 -> bubble. Flush overrides stall.
  - else hazard=1 -> bubble; if_instr is held upstream and re-presented the next cycle.
  - else if_valid=0 -> bubble.
  - else ex_instruction=if_instr, ex_regA/ex_regB=resolved operands, ex_dest, ex_is_load=(opcode==6'h23), ex_valid=1.
- Bubble: ex_instruction=NOP_INSTR, ex_regA=ex_regB=0, ex_dest=0, ex_is_load=0, ex_valid=0.
- Latency: 1 cycle from if_instr to ex_* outputs. Stall adds exactly 1 cycle, because after the bubble the lw has left EX.
- Register-file write happens on the rising edge when wb_en=1, independent of stall and flush.
- Reset asserted mid-stall or mid-write: state is cleared at once and the pending write is lost. After deassertion the first edge behaves as a normal decode.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants: OP_RTYPE 6'h00, OP_BEQ 6'h04, OP_BNE 6'h05, OP_ADDI 6'h08, OP_ADDIU 6'h09, OP_SLTI 6'h0A, OP_SLTIU 6'h0B, OP_ANDI 6'h0C, OP_ORI 6'h0D, OP_XORI 6'h0E, OP_LW 6'h23, OP_SW 6'h2B;
  - NOP_INSTR;
  - field-slice constants.
- Sub-module reg_file: 2 asynchronous read ports, 1 synchronous write port, async reset clear, $0 hardwired. Forward and write-through muxing stays in id_ex_stage.

Test Plan:
- Reset mid-run: load instr 32'h00200020 with GPR1=5, assert rst between edges -> outputs 0 and ex_valid=0 immediately; after release, reading GPR1 returns 0.
- Write-through: wb_en=1, wb_addr=1, wb_data=32'h7FFFFFFF in the same cycle as if_instr=32'h00200020, if_valid=1 -> next edge ex_regA=32'h7FFFFFFF, ex_regB=0, ex_dest=0, ex_valid=1.
- $0 protection and priority:
  - wb to addr 0 with 32'hFFFFFFFF, then rs=0 -> ex_regA=0.
  - mem_fwd addr2=5 and wb addr2=9 in the same cycle, rs=2 -> ex_regA=5.
- Load-use stall:
  - EX holds 32'h8C01700F (lw, dest 1); if_instr=32'h00200020 (rs=1) -> id_ready=0, next edge ex_valid=0 and ex_instruction=0.
  - Following edge, with WB forwarding of lw data 32'h1234, -> ex_regA=32'h1234, ex_valid=1.
- rt hazard filter: EX lw dest 1, if_instr=32'h20010001 (addi, rt=1 only) -> id_ready=1, no bubble. Same with beq 32'h10010001 -> stall.
- Flush over stall: hazard active and flush=1 -> id_ready=1, next edge bubble; next valid instruction issues normally.
